vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 79 +++++++
 tb/tb_vga_timing_gen.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, active-video flag, and
// active-low sync pulses delayed to line up with downstream registered colour.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int PW      = SYNC_DELAY + 1;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]    hc, vc;
  logic [9:0]    hc_next, vc_next;
  logic          h_wrap, v_wrap;
  logic          hs_raw_next, vs_raw_next;
  logic [PW-1:0] hs_pipe, vs_pipe;

  always_comb begin
    h_wrap      = (hc == H_LAST);
    v_wrap      = (vc == V_LAST);
    hc_next     = h_wrap ? '0 : hc + 10'd1;
    vc_next     = vc;
    if (h_wrap) begin
      vc_next = v_wrap ? '0 : vc + 10'd1;
    end
    hs_raw_next = !((hc_next >= HS_BEG) && (hc_next < HS_END));
    vs_raw_next = !((vc_next >= VS_BEG) && (vc_next < VS_END));
  end

  // Stage 0 of each sync pipe lines up with DrawX/DrawY; the last stage is the output.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc          <= '0;
      vc          <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
      hs_pipe     <= '1;
      vs_pipe     <= '1;
    end else begin
      hc          <= hc_next;
      vc          <= vc_next;
      blank       <= (hc_next < H_ACT) && (vc_next < V_ACT);
      frame_start <= h_wrap && v_wrap;
      hs_pipe     <= (hs_pipe << 1) | PW'(hs_raw_next);
      vs_pipe     <= (vs_pipe << 1) | PW'(vs_raw_next);
    end
  end

  assign DrawX = hc;
  assign DrawY = vc;
  assign hs    = hs_pipe[SYNC_DELAY];
  assign vs    = vs_pipe[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: expected raster state is derived from the cycle count since
// reset release, queued per cycle, and compared by an independent monitor.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int SHA = 16, SHF = 4, SHW = 6, SHB = 4;
  localparam int SVA = 12, SVF = 2, SVW = 2, SVB = 3;
  localparam int SHT = SHA + SHF + SHW + SHB;
  localparam int SVT = SVA + SVF + SVW + SVB;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       fs;
  } obs_t;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] d_x, d_y, a_x, a_y, b_x, b_y;
  logic       d_blank, d_hs, d_vs, d_fs;
  logic       a_blank, a_hs, a_vs, a_fs;
  logic       b_blank, b_hs, b_vs, b_fs;

  obs_t   q_d[$], q_a[$], q_b[$];
  int     n_vec = 0;
  int     n_bad = 0;
  longint t = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(.SYNC_DELAY(1)) u_def (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(d_x), .DrawY(d_y),
    .blank(d_blank), .hs(d_hs), .vs(d_vs), .frame_start(d_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHW), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVW), .V_BP(SVB), .SYNC_DELAY(0)
  ) u_s0 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(a_x), .DrawY(a_y),
    .blank(a_blank), .hs(a_hs), .vs(a_vs), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHW), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVW), .V_BP(SVB), .SYNC_DELAY(3)
  ) u_s3 (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(b_x), .DrawY(b_y),
    .blank(b_blank), .hs(b_hs), .vs(b_vs), .frame_start(b_fs)
  );

  // Outputs after t clock edges since reset release, from raster arithmetic.
  function automatic obs_t model(input int ha, input int hf, input int hw, input int hb,
                                 input int va, input int vf, input int vw, input int vb,
                                 input int d, input longint tt);
    obs_t   o;
    int     ht, vt;
    longint fr, tf, td;
    ht      = ha + hf + hw + hb;
    vt      = va + vf + vw + vb;
    fr      = longint'(ht) * vt;
    tf      = tt % fr;
    o.x     = 10'(tf % ht);
    o.y     = 10'(tf / ht);
    o.blank = ((tf % ht) < ha) && ((tf / ht) < va);
    o.fs    = (tt > 0) && (tf == 0);
    if (tt < d) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end else begin
      td   = (tt - d) % fr;
      o.hs = !(((td % ht) >= ha + hf) && ((td % ht) < ha + hf + hw));
      o.vs = !(((td / ht) >= va + vf) && ((td / ht) < va + vf + vw));
    end
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0d, time %0t)", name, act, exp, t, $time);
    end
  endtask

  task automatic chk_obs(input string tag, input obs_t act, input obs_t exp);
    chk({tag, ".DrawX"},       int'(act.x),     int'(exp.x));
    chk({tag, ".DrawY"},       int'(act.y),     int'(exp.y));
    chk({tag, ".blank"},       int'(act.blank), int'(exp.blank));
    chk({tag, ".hs"},          int'(act.hs),    int'(exp.hs));
    chk({tag, ".vs"},          int'(act.vs),    int'(exp.vs));
    chk({tag, ".frame_start"}, int'(act.fs),    int'(exp.fs));
  endtask

  // Monitor: the DUT presents a new raster sample every cycle.
  initial begin
    obs_t act, exp;
    forever begin
      @(negedge vga_clk);
      if (q_d.size() > 0) begin
        exp = q_d.pop_front();
        act = {d_x, d_y, d_blank, d_hs, d_vs, d_fs};
        chk_obs("def", act, exp);
      end
      if (q_a.size() > 0) begin
        exp = q_a.pop_front();
        act = {a_x, a_y, a_blank, a_hs, a_vs, a_fs};
        chk_obs("s0", act, exp);
      end
      if (q_b.size() > 0) begin
        exp = q_b.pop_front();
        act = {b_x, b_y, b_blank, b_hs, b_vs, b_fs};
        chk_obs("s3", act, exp);
      end
    end
  end

  task automatic step();
    @(posedge vga_clk);
    if (reset_n) t++;
    #2;
  endtask

  task automatic push();
    q_d.push_back(model(640, 16, 96, 48, 480, 10, 2, 33, 1, t));
    q_a.push_back(model(SHA, SHF, SHW, SHB, SVA, SVF, SVW, SVB, 0, t));
    q_b.push_back(model(SHA, SHF, SHW, SHB, SVA, SVF, SVW, SVB, 3, t));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      step();
      push();
    end
  endtask

  // Assert mid-cycle so the negedge sample sees the asynchronous clear.
  task automatic rst(input int n);
    step();
    reset_n = 1'b0;
    t = 0;
    push();
    repeat (n - 1) begin
      step();
      push();
    end
    step();
    reset_n = 1'b1;
    push();
  endtask

  initial begin
    rst(3);
    // Two small frames plus the point (25,15): inside both small-raster sync pulses.
    run(2 * SHT * SVT + 15 * SHT + 25);
    rst(1);
    run(2500);
    for (int i = 0; i < 8; i++) begin
      run(int'($urandom_range(20, 2000)));
      rst(int'($urandom_range(1, 3)));
    end
    run(3 * SHT * SVT + 7);
    step();
    @(negedge vga_clk);
    #1;
    chk("queue_drained", q_d.size() + q_a.size() + q_b.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
